// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions: abc_defg patterns, special digit codes, reader FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sevenseg_pkg;

    // Segment patterns, bit6 = a ... bit0 = g
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Decoded values for a dark digit and an unrecognised pattern
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Maps an abc_defg segment pattern back to its 4-bit digit, flagging unknown patterns.
// Latency: combinational.
// Backpressure: none.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       err
);

    // Exact inverse of the encoder table; blank is legal, anything else is an error
    always_comb begin
        digit = DIGIT_ERR;
        err   = 1'b0;
        unique case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = DIGIT_BLANK;
            default: begin
                digit = DIGIT_ERR;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sevenseg_reader.sv
// Samples a multiplexed 7-segment bus, debounces each strobed digit and publishes whole frames.
// Latency: pin change to frame_valid = 2 sync + STABLE_CYCLES + 1 cycles for the final digit.
// Backpressure: none; frames are posted with a one-cycle frame_valid pulse and held until the next.
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);

    localparam int                  CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]       CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);

    logic [6:0]              seg_s1, s_seg;
    logic [NUM_DIGITS-1:0]   en_s1, s_en;

    state_t                  state;
    logic [NUM_DIGITS-1:0]   lat_en;
    logic [6:0]              lat_seg;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic [NUM_DIGITS-1:0]   seen;

    logic [3:0]              dec_val;
    logic                    dec_err;
    logic                    en_onehot;
    logic                    en_same;
    logic                    seg_same;
    logic                    seen_full;

    // Two-flop synchronizers for the asynchronous panel pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1 <= '0;
            s_seg  <= '0;
            en_s1  <= '0;
            s_en   <= '0;
        end else begin
            seg_s1 <= seg_in;
            s_seg  <= seg_s1;
            en_s1  <= dig_en;
            s_en   <= en_s1;
        end
    end

    sevenseg_decode u_decode (
        .seg   (s_seg),
        .digit (dec_val),
        .err   (dec_err)
    );

    // Strobe classification and comparison against the latched sample
    always_comb begin
        en_onehot = (s_en != '0) && ((s_en & (s_en - EN_ONE)) == '0);
        en_same   = (s_en == lat_en);
        seg_same  = (s_seg == lat_seg);
        seen_full = &seen;
    end

    // Debounce FSM, shadow capture and frame publication
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lat_en      <= '0;
            lat_seg     <= '0;
            cnt         <= '0;
            shadow_dig  <= '0;
            shadow_err  <= '0;
            seen        <= '0;
            digits_out  <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;

            // Publish one cycle after the last missing digit lands in the shadow
            if (seen_full) begin
                digits_out  <= shadow_dig;
                digit_err   <= shadow_err;
                frame_valid <= 1'b1;
                seen        <= '0;
            end

            case (state)
                IDLE: begin
                    if (en_onehot) begin
                        state   <= TRACK;
                        lat_en  <= s_en;
                        lat_seg <= s_seg;
                        cnt     <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end

                TRACK: begin
                    if (!en_onehot) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!en_same || !seg_same) begin
                        // Any change restarts the stability window on the new sample
                        lat_en  <= s_en;
                        lat_seg <= s_seg;
                        cnt     <= CNT_ONE;
                    end else if (cnt == CNT_MAX - CNT_ONE) begin
                        // Stable long enough: commit; a repeat commit simply overwrites
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (lat_en[i]) begin
                                shadow_dig[4*i +: 4] <= dec_val;
                                shadow_err[i]        <= dec_err;
                            end
                        end
                        seen  <= (seen_full ? '0 : seen) | lat_en;
                        cnt   <= CNT_MAX;
                        state <= HELD;
                    end else if (cnt < CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    // Only a strobe change ends the hold; segment changes are ignored
                    if (!en_same) begin
                        if (en_onehot) begin
                            state   <= TRACK;
                            lat_en  <= s_en;
                            lat_seg <= s_seg;
                            cnt     <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/sevenseg_reader.md
Name: sevenseg_reader

Overview:
Receive-side counterpart of the segment encoder. Samples a multiplexed, externally driven 7-segment bus (segment lines plus one-hot digit strobes) from a Smart Room panel. Debounces each strobed digit, decodes the abc_defg pattern back to a 4-bit value, and publishes a complete multi-digit frame with a one-cycle valid pulse. Sits between the panel input pins and the room controller logic.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits / strobe lines.
- STABLE_CYCLES, 8: consecutive identical synchronized samples required before a digit is accepted; legal range 2..255.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- seg_in, input, 7: segment lines, active-high; bit6=a … bit0=g (abc_defg). Asynchronous to clk.
- dig_en, input, NUM_DIGITS: digit strobes, active-high, expected one-hot; bit k selects digit k. Asynchronous to clk.
- digits_out, output, 4*NUM_DIGITS: last complete frame; digit k in bits [4k+3:4k].
- digit_err, output, NUM_DIGITS: per-digit flag for the last frame; 1 = undecodable pattern.
- frame_valid, output, 1: one-cycle pulse when digits_out and digit_err update.

Behaviour:
- Reset: digits_out=0, digit_err=0, frame_valid=0, synchronizers=0, shadow=0, seen mask=0, counter=0, state=IDLE. Reset asserted mid-frame discards all partial captures.
- Input sync: seg_in and dig_en each pass through a 2-flop synchronizer. All logic below uses synchronized values (s_seg, s_en).
- Decode (combinational on s_seg):
  - The ten encoder patterns map to 0..9: 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000 → 4'hF (blank), err=0.
  - Any other pattern → 4'hE, err=1.
- State machine:
  - IDLE: s_en not exactly one-hot (zero or multiple bits). Counter=0. Enter TRACK when s_en becomes one-hot; latch index k and pattern; counter=1.
  - TRACK: each cycle s_en and s_seg equal the latched values → counter+1. When the counter reaches STABLE_CYCLES, on that edge write decoded value and err into shadow slot k, set seen[k], and go to HELD.
    - Pattern changes with the same strobe → re-latch pattern, counter=1, stay in TRACK.
    - Different one-hot strobe → re-latch index and pattern, counter=1.
    - Non-one-hot strobe → IDLE.
  - HELD: no further captures for the digit. Leave when s_en changes: one-hot → TRACK (counter=1); otherwise → IDLE. Pattern changes while in HELD are ignored.
- Frame completion:
  - On the cycle after seen becomes all-ones, load digits_out/digit_err from shadow, pulse frame_valid for one cycle, and clear seen.
  - A commit to digit k while seen[k] is already 1 overwrites shadow slot k. The newest value wins and seen is unchanged.
- Latency: pin change to frame_valid = 2 (sync) + STABLE_CYCLES + 1 cycles for the final digit.
- Counter width: $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.
- digits_out and digit_err hold their values between frames.

Decomposition:
- Package sevenseg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants (shared with the encoder);
  - DIGIT_BLANK=4'hF and DIGIT_ERR=4'hE;
  - the state enum {IDLE, TRACK, HELD}.
- One sub-module, sevenseg_decode: combinational 7-bit pattern → {err, 4-bit digit}. It is the exact inverse of the encoder table and is reusable in benches.

Test Plan:
- Scan digits 0..3 with patterns for 1,2,3,4, each held 20 cycles → one frame_valid pulse; digits_out=16'h4321, digit_err=4'b0000.
- Digit 2 driven 0000000, others 8 → digits_out=16'h8F88, digit_err=0.
- Digit 1 driven 1000000, others 0 → digits_out=16'h00E0, digit_err=4'b0010.
- Glitch: digit 0 pattern 5 toggles to 6 for one cycle every 5 cycles with STABLE_CYCLES=8 → no commit for digit 0 and no frame_valid while glitching. Hold 6 steady for 8 cycles → digit 0 commits as 6.
- dig_en=4'b0011 for 30 cycles → stays IDLE, nothing committed. Then legal scan of 9,9,9,9 → digits_out=16'h9999.
- Reset asserted after 3 of 4 digits captured, then a full scan of 7,0,7,0 → single frame_valid; digits_out=16'h0707. No stale digits from before reset appear.
